// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: program handshake, ROM fetch and branch feedback.
// The master side is the sequencer (owns PC); the slave side is the
// surrounding start logic, instruction ROM, decoder and ALU.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned OFF_W   = 8,
  parameter int unsigned CNT_W   = 16
);
  logic               Start;
  logic [PC_W-1:0]    StartAddr;
  logic [INSTR_W-1:0] InstrIn;
  logic               BranchRel;
  logic               Taken;
  logic [OFF_W-1:0]   BranchOff;
  logic [PC_W-1:0]    PC;
  logic [5:0]         Instruction;
  logic               Valid;
  logic               Done;
  logic [CNT_W-1:0]   RetiredCnt;

  modport master (
    input  Start, StartAddr, InstrIn, BranchRel, Taken, BranchOff,
    output PC, Instruction, Valid, Done, RetiredCnt
  );

  modport slave (
    output Start, StartAddr, InstrIn, BranchRel, Taken, BranchOff,
    input  PC, Instruction, Valid, Done, RetiredCnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch control: sequential or PC-relative next PC,
// Start/Done program handshake, halt detection and a saturating
// retired-instruction counter.
module fetch_sequencer #(
  parameter int unsigned        PC_W      = 10,
  parameter int unsigned        INSTR_W   = 9,
  parameter int unsigned        OFF_W     = 8,
  parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic             done;
  logic [CNT_W-1:0] cnt;

  logic             is_halt;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  pc_next;

  // Decode halt word and compute the next PC for a retiring instruction
  always_comb begin
    is_halt = (bus.InstrIn == HALT_WORD);
    off_ext = {{(PC_W-OFF_W){bus.BranchOff[OFF_W-1]}}, bus.BranchOff};
    if (bus.BranchRel && bus.Taken)
      pc_next = pc + off_ext;
    else
      pc_next = pc + PC_W'(1);
  end

  // Sequencer state, PC, Done flag and retired counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= '0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            pc    <= bus.StartAddr;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (is_halt) begin
            done  <= 1'b1;
            state <= HALT;
          end else begin
            pc <= pc_next;
            if (cnt != '1)
              cnt <= cnt + CNT_W'(1);
          end
        end
        HALT: begin
          if (bus.Start) begin
            done  <= 1'b0;
            pc    <= bus.StartAddr;
            cnt   <= '0;
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output drive: registered PC/Done/count, live-instruction flag from fetch
  always_comb begin
    bus.PC          = pc;
    bus.Done        = done;
    bus.RetiredCnt  = cnt;
    bus.Instruction = bus.InstrIn[INSTR_W-1 -: 6];
    bus.Valid       = (state == RUN) && !is_halt;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then randomized programs,
// checked against a behavioural model. A second instance with a narrow
// counter exercises saturation.
module tb_fetch_sequencer;
  localparam logic [8:0] HALT = 9'h1FF;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic       start = 1'b0;
  logic [9:0] start_addr = '0;
  logic       br = 1'b0;
  logic       taken = 1'b0;
  logic [7:0] off = '0;
  logic [8:0] rom [0:1023];

  fetch_sequencer_if #(.PC_W(10), .INSTR_W(9), .OFF_W(8), .CNT_W(16)) bus_a ();
  fetch_sequencer_if #(.PC_W(10), .INSTR_W(9), .OFF_W(8), .CNT_W(4))  bus_s ();

  assign bus_a.Start     = start;
  assign bus_a.StartAddr = start_addr;
  assign bus_a.BranchRel = br;
  assign bus_a.Taken     = taken;
  assign bus_a.BranchOff = off;
  assign bus_a.InstrIn   = rom[bus_a.PC];
  assign bus_s.Start     = start;
  assign bus_s.StartAddr = start_addr;
  assign bus_s.BranchRel = br;
  assign bus_s.Taken     = taken;
  assign bus_s.BranchOff = off;
  assign bus_s.InstrIn   = rom[bus_s.PC];

  fetch_sequencer #(.PC_W(10), .INSTR_W(9), .OFF_W(8), .HALT_WORD(9'h1FF), .CNT_W(16))
    u_dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_a));
  fetch_sequencer #(.PC_W(10), .INSTR_W(9), .OFF_W(8), .HALT_WORD(9'h1FF), .CNT_W(4))
    u_small (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_s));

  int checks = 0;
  int errors = 0;

  // Reference model: program position, counters, and whether a program is live/finished
  int mpc, mcnt, msmall;
  bit m_run, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [8:0] w;
    w = rom[mpc];
    chk("pc",       32'(bus_a.PC), 32'(mpc));
    chk("pc_small", 32'(bus_s.PC), 32'(mpc));
    chk("done",     32'(bus_a.Done), 32'(m_done));
    chk("valid",    32'(bus_a.Valid), 32'(m_run && (w != HALT)));
    chk("instr",    32'(bus_a.Instruction), 32'(w[8:3]));
    chk("retired",  32'(bus_a.RetiredCnt), 32'(mcnt));
    chk("retired_small", 32'(bus_s.RetiredCnt), 32'(msmall));
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; mpc = 0; mcnt = 0; msmall = 0;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (start) begin
        mpc = int'(start_addr); mcnt = 0; msmall = 0; m_run = 1; m_done = 0;
      end
    end else if (rom[mpc] == HALT) begin
      m_run = 0; m_done = 1;
    end else begin
      if (mcnt < 65535) mcnt++;
      if (msmall < 15) msmall++;
      if (br && taken) mpc = (mpc + int'($signed(off)) + 1024) % 1024;
      else             mpc = (mpc + 1) % 1024;
    end
  endtask

  // Check at posedge+2, advance model, land at posedge+1 for the next drive
  task automatic step();
    #1;
    check_all();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  // Asynchronous reset pulse between edges, checked before any clock
  task automatic mid_reset();
    start = 1'b0;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_pc", 32'(bus_a.PC), 32'd0);
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_to_halt(input int max);
    for (int i = 0; i < max && !m_done; i++) step();
    chk("halt_reached", 32'(bus_a.Done), 32'd1);
  endtask

  int cnt_before;

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 9'h1FE));
    model_reset();
    #12;
    check_all();
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Straight-line program with halt at 3
    rom[3] = HALT;
    start = 1'b1; start_addr = 10'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("a_retired", 32'(bus_a.RetiredCnt), 32'd3);
    chk("a_done", 32'(bus_a.Done), 32'd1);

    // Start ignored while running, then backward taken branch
    start = 1'b1; start_addr = 10'd4;
    step();
    start = 1'b1; start_addr = 10'd300;
    step();
    start = 1'b0;
    chk("b_start_ignored", 32'(bus_a.PC), 32'd5);
    br = 1'b1; taken = 1'b1; off = 8'hFD;
    step();
    br = 1'b0; taken = 1'b0;
    chk("b_br_back", 32'(bus_a.PC), 32'd2);
    run_to_halt(10);

    // Same branch not taken, then async reset at PC=7
    start = 1'b1; start_addr = 10'd5;
    step();
    start = 1'b0; br = 1'b1; taken = 1'b0; off = 8'hFD;
    step();
    br = 1'b0;
    chk("c_br_not_taken", 32'(bus_a.PC), 32'd6);
    step();
    chk("c_at7", 32'(bus_a.PC), 32'd7);
    mid_reset();

    // Restart from HALT at 100
    rom[102] = HALT;
    start = 1'b1; start_addr = 10'd100;
    step();
    start = 1'b0;
    run_to_halt(10);
    step();
    start = 1'b1; start_addr = 10'd100;
    step();
    start = 1'b0;
    chk("d_restart_pc", 32'(bus_a.PC), 32'd100);
    chk("d_restart_done", 32'(bus_a.Done), 32'd0);
    chk("d_restart_cnt", 32'(bus_a.RetiredCnt), 32'd0);
    run_to_halt(10);

    // Forward branch across the top of the address space
    rom[10] = HALT;
    start = 1'b1; start_addr = 10'd1020;
    step();
    start = 1'b0; br = 1'b1; taken = 1'b1; off = 8'd10;
    step();
    br = 1'b0; taken = 1'b0;
    chk("e_br_wrap", 32'(bus_a.PC), 32'd6);
    run_to_halt(10);

    // Sequential wrap 1023 -> 0
    start = 1'b1; start_addr = 10'd1022;
    step();
    start = 1'b0;
    step();
    step();
    chk("f_seq_wrap", 32'(bus_a.PC), 32'd0);
    run_to_halt(10);

    // Zero-offset self loop at 9; long enough to saturate the narrow counter
    start = 1'b1; start_addr = 10'd9;
    step();
    start = 1'b0; br = 1'b1; taken = 1'b1; off = 8'd0;
    cnt_before = int'(bus_a.RetiredCnt);
    for (int i = 0; i < 4; i++) step();
    chk("g_loop_pc", 32'(bus_a.PC), 32'd9);
    chk("g_loop_cnt", 32'(bus_a.RetiredCnt), 32'(cnt_before + 4));
    for (int i = 0; i < 16; i++) step();
    chk("g_sat_small", 32'(bus_s.RetiredCnt), 32'd15);
    br = 1'b0; taken = 1'b0;
    run_to_halt(10);

    // Randomized programs with sporadic halts and resets
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom_range(0, 9'h1FE));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        start      = ($urandom_range(0, 5) == 0);
        start_addr = 10'($urandom);
        br         = 1'($urandom);
        taken      = 1'($urandom);
        off        = 8'($urandom);
        step();
      end
    end
    #1;
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
